// File: rtl/adv7513_reconf_ctrl.sv
// ----------------------------------------------------------------------------
// adv7513_reconf_ctrl
// Watches NUM_CH packed config channels, synchronises them, debounces changes,
// commits a stable snapshot and requests one reconfiguration from the ADV7513
// I2C config engine through a level req / pulse ack handshake.
// Optional feature: define RECONF_TIMEOUT_EN to add an ack timeout with a
// sticky timeout_err flag. Without it the request waits for ack indefinitely.
// ----------------------------------------------------------------------------
module adv7513_reconf_ctrl #(
    parameter int NUM_CH        = 3,
    parameter int CH_W          = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter logic [NUM_CH*CH_W-1:0] RESET_VALUE = '0,
    parameter bit REQ_ON_RESET  = 1'b1,
    parameter int TIMEOUT       = 1024
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_CH*CH_W-1:0]   cfg_in,
    output logic [NUM_CH*CH_W-1:0]   cfg_out,
    output logic [NUM_CH-1:0]        change_mask,
    output logic                     reconf_req,
    input  logic                     reconf_ack,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int CFG_W = NUM_CH * CH_W;
    localparam int CNT_W = $clog2(SETTLE_CYCLES) + 1;
    localparam int TO_W  = $clog2(TIMEOUT) + 1;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT - 1);

    // Reject parameter values the debounce and timeout logic cannot express
    if (SYNC_STAGES < 1) begin : g_bad_sync
        $error("adv7513_reconf_ctrl: SYNC_STAGES must be >= 1");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("adv7513_reconf_ctrl: SETTLE_CYCLES must be >= 1");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("adv7513_reconf_ctrl: TIMEOUT must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_REQ    = 2'd2
    } state_t;

    state_t                           state_q, state_d;
    logic [SYNC_STAGES-1:0][CFG_W-1:0] sync_q, sync_d;
    logic [CFG_W-1:0]                 cfg_p_q, cfg_p_d;
    logic [CFG_W-1:0]                 cfg_out_q, cfg_out_d;
    logic [NUM_CH-1:0]                change_mask_q, change_mask_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic                             reconf_req_q, reconf_req_d;
    logic                             busy_q, busy_d;
    logic [CFG_W-1:0]                 cfg_s;
    logic [NUM_CH-1:0]                ch_diff;

`ifdef RECONF_TIMEOUT_EN
    logic [TO_W-1:0]                  to_cnt_q, to_cnt_d;
    logic                             timeout_err_q, timeout_err_d;
`endif

    assign cfg_s = sync_q[SYNC_STAGES-1];

    // Shift the live config through the synchroniser chain every cycle
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = cfg_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        cfg_p_d = cfg_s;
    end

    // Per-channel comparison of the synced config against the last commit
    always_comb begin
        ch_diff = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_diff[i] = (cfg_s[i*CH_W +: CH_W] != cfg_out_q[i*CH_W +: CH_W]);
        end
    end

    // Next-state logic: debounce in SETTLE, hold the snapshot in REQ
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cfg_out_d     = cfg_out_q;
        change_mask_d = change_mask_q;
        reconf_req_d  = reconf_req_q;
`ifdef RECONF_TIMEOUT_EN
        to_cnt_d      = to_cnt_q;
        timeout_err_d = timeout_err_q;
`endif

        case (state_q)
            S_IDLE: begin
                reconf_req_d = 1'b0;
                if (cfg_s != cfg_out_q) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end
            end

            S_SETTLE: begin
                if (cfg_s != cfg_p_q) begin
                    cnt_d = '0;
                end else if (cfg_s == cfg_out_q) begin
                    // The change came back to the committed value: nothing to do
                    state_d = S_IDLE;
                end else if (cnt_q == SETTLE_LAST) begin
                    cfg_out_d     = cfg_s;
                    change_mask_d = ch_diff;
                    reconf_req_d  = 1'b1;
                    state_d       = S_REQ;
`ifdef RECONF_TIMEOUT_EN
                    to_cnt_d      = '0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_REQ: begin
                if (reconf_ack) begin
                    reconf_req_d = 1'b0;
                    state_d      = S_IDLE;
                end
`ifdef RECONF_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    // Give up on the engine but keep the snapshot, so IDLE does
                    // not immediately ask again for the same config
                    reconf_req_d  = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end

            default: begin
                state_d      = S_IDLE;
                reconf_req_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers; reset either idles or requests RESET_VALUE
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q        <= {SYNC_STAGES{RESET_VALUE}};
            cfg_p_q       <= RESET_VALUE;
            cfg_out_q     <= RESET_VALUE;
            change_mask_q <= '0;
            cnt_q         <= '0;
            state_q       <= REQ_ON_RESET ? S_REQ : S_IDLE;
            reconf_req_q  <= REQ_ON_RESET;
            busy_q        <= REQ_ON_RESET;
        end else begin
            sync_q        <= sync_d;
            cfg_p_q       <= cfg_p_d;
            cfg_out_q     <= cfg_out_d;
            change_mask_q <= change_mask_d;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            reconf_req_q  <= reconf_req_d;
            busy_q        <= busy_d;
        end
    end

`ifdef RECONF_TIMEOUT_EN
    // Ack timeout counter and sticky error flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            to_cnt_q      <= to_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign cfg_out     = cfg_out_q;
    assign change_mask = change_mask_q;
    assign reconf_req  = reconf_req_q;
    assign busy        = busy_q;

endmodule
